dmem_access_unit: RTL and testbench

Data-memory access stage between the execute stage and the load unit. Accepts load/store requests through a valid/ready handshake, formats stores into byte enables and replicated write data, and rejects misaligned or illegal accesses. Issues word-addressed requests to the memory port with a req/gnt handshake. Keeps a small in-order FIFO of pending load tags (byte offset, funct3) so each returning read word reaches the load unit with the matching `addr[1:0]`/funct3.

---
 rtl/dmem_access_unit.sv | 113 +++++++++++
 tb/tb_dmem_access_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: formats load/store requests, rejects faulting ones, drives the
// req/gnt memory port and tracks pending load tags so read words return with their offset/funct3.
module dmem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-3:0] o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [31:0]           o_mem_wdata,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [31:0]           i_mem_rdata,
  output logic                  o_rsp_valid,
  output logic [1:0]            o_rsp_addr,
  output logic [2:0]            o_rsp_funct3,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_fault,
  output logic [ADDR_WIDTH-1:0] o_fault_addr
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_nxt;
  logic [4:0] tags [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0] occupancy;
  logic [1:0] req_off;
  logic [2:0] req_f3;
  logic granting, granting_load, accept, fault, misaligned, bad_f3, push, pop;
  logic [3:0] be;
  logic [31:0] wdata;
  assign granting = state == REQ && i_mem_gnt;
  assign granting_load = granting && !o_mem_we;
  assign occupancy = {1'b0, count} + (CW+1)'(granting_load);
  assign o_req_ready = !i_rst && (state == IDLE || granting) && occupancy < (CW+1)'(DEPTH);
  assign accept = i_req_valid && o_req_ready;
  assign push = granting_load;
  assign pop = i_mem_rvalid && count != '0;
  always_comb begin
    misaligned = (i_req_funct3[1:0] == 2'b01 && i_req_addr[0]) ||
                 (i_req_funct3[1:0] == 2'b10 && i_req_addr[1:0] != 2'b00);
    bad_f3 = i_req_we ? i_req_funct3[2] || i_req_funct3[1:0] == 2'b11
                      : i_req_funct3[1:0] == 2'b11 || i_req_funct3 == 3'b110;
    fault = misaligned || bad_f3;
    be = !i_req_we ? 4'b0000 :
         i_req_funct3[1:0] == 2'b00 ? 4'b0001 << i_req_addr[1:0] :
         i_req_funct3[1:0] == 2'b01 ? 4'b0011 << {i_req_addr[1], 1'b0} : 4'b1111;
    wdata = i_req_funct3[1:0] == 2'b00 ? {4{i_req_wdata[7:0]}} :
            i_req_funct3[1:0] == 2'b01 ? {2{i_req_wdata[15:0]}} : i_req_wdata;
    state_nxt = accept && !fault ? REQ : granting ? IDLE : state;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mem_req <= 1'b0;
      o_mem_we <= 1'b0;
      o_mem_addr <= '0;
      o_mem_be <= 4'b0000;
      o_mem_wdata <= '0;
      req_off <= 2'b00;
      req_f3 <= 3'b000;
      o_fault <= 1'b0;
      o_fault_addr <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_addr <= 2'b00;
      o_rsp_funct3 <= 3'b000;
      o_rsp_rdata <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (accept && !fault) begin
        o_mem_req <= 1'b1;
        o_mem_we <= i_req_we;
        o_mem_addr <= i_req_addr[ADDR_WIDTH-1:2];
        o_mem_be <= be;
        o_mem_wdata <= wdata;
        req_off <= i_req_addr[1:0];
        req_f3 <= i_req_funct3;
      end else if (granting) begin
        o_mem_req <= 1'b0;
      end
      o_fault <= accept && fault;
      if (accept && fault) o_fault_addr <= i_req_addr;
      o_rsp_valid <= pop;
      if (pop) begin
        o_rsp_addr <= tags[rd_ptr][4:3];
        o_rsp_funct3 <= tags[rd_ptr][2:0];
        o_rsp_rdata <= i_mem_rdata;
        rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) tags[wr_ptr] <= {req_off, req_f3};
  end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed stimulus, queue-based reference model checked every cycle
// plus hand-computed literal expectations.
module tb_dmem_access_unit;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_we = 0, ready;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [2:0] req_f3 = 0;
  logic mem_req, mem_we, gnt = 0, rvalid = 0;
  logic [29:0] mem_addr;
  logic [3:0] mem_be;
  logic [31:0] mem_wdata, rdata = 0, rsp_rdata, fault_addr;
  logic rsp_valid, fault;
  logic [1:0] rsp_addr;
  logic [2:0] rsp_f3;
  int checks = 0, errors = 0;
  dmem_access_unit #(.ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready),
    .i_req_addr(req_addr), .i_req_we(req_we), .i_req_funct3(req_f3), .i_req_wdata(req_wdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_be(mem_be),
    .o_mem_wdata(mem_wdata), .i_mem_gnt(gnt), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata),
    .o_rsp_valid(rsp_valid), .o_rsp_addr(rsp_addr), .o_rsp_funct3(rsp_f3),
    .o_rsp_rdata(rsp_rdata), .o_fault(fault), .o_fault_addr(fault_addr));
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit is_fault(bit w, logic [2:0] f, logic [31:0] a);
    int size;
    if (w) begin
      if (f > 3'd2) return 1;
    end else if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1;
    size = 1 << f[1:0];
    return (a % size) != 0;
  endfunction
  bit m_busy = 0, m_we = 0, m_rsp_v = 0, m_fault = 0, m_gl, m_acc;
  logic [29:0] m_waddr = 0;
  logic [3:0] m_be = 0;
  logic [31:0] m_wdata = 0, m_rsp_data = 0, m_fault_addr = 0;
  logic [1:0] m_off = 0, m_rsp_addr = 0;
  logic [2:0] m_f3 = 0, m_rsp_f3 = 0;
  logic [4:0] m_tag;
  logic [4:0] pend[$];
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_we = 0; m_waddr = 0; m_be = 0; m_wdata = 0; m_off = 0; m_f3 = 0;
      m_rsp_v = 0; m_rsp_addr = 0; m_rsp_f3 = 0; m_rsp_data = 0; m_fault = 0; m_fault_addr = 0;
      pend.delete();
    end else begin
      m_gl = m_busy && gnt && !m_we;
      m_acc = req_valid && (!m_busy || gnt) && (pend.size() + int'(m_gl) < DEPTH);
      m_rsp_v = rvalid && pend.size() > 0;
      if (m_rsp_v) begin
        m_tag = pend.pop_front();
        m_rsp_addr = m_tag[4:3];
        m_rsp_f3 = m_tag[2:0];
        m_rsp_data = rdata;
      end
      if (m_gl) pend.push_back({m_off, m_f3});
      if (m_busy && gnt) m_busy = 0;
      m_fault = m_acc && is_fault(req_we, req_f3, req_addr);
      if (m_fault) m_fault_addr = req_addr;
      if (m_acc && !m_fault) begin
        m_busy = 1; m_we = req_we; m_waddr = req_addr[31:2]; m_off = req_addr[1:0]; m_f3 = req_f3;
        m_be = !req_we ? 4'h0 : req_f3 == 3'd0 ? 4'(1 << req_addr[1:0]) :
               req_f3 == 3'd1 ? 4'(3 << (req_addr[1:0] & 2'b10)) : 4'hf;
        m_wdata = req_f3 == 3'd0 ? req_wdata[7:0] * 32'h01010101 :
                  req_f3 == 3'd1 ? req_wdata[15:0] * 32'h00010001 : req_wdata;
      end
    end
  end
  always @(negedge clk) begin
    chk("ready", ready, !rst && (!m_busy || gnt) &&
        (pend.size() + ((m_busy && gnt && !m_we) ? 1 : 0) < DEPTH));
    chk("mem_req", mem_req, m_busy);
    if (m_busy) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_waddr);
      chk("mem_be", mem_be, m_be);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("rsp_valid", rsp_valid, m_rsp_v);
    if (m_rsp_v) begin
      chk("rsp_addr", rsp_addr, m_rsp_addr);
      chk("rsp_funct3", rsp_f3, m_rsp_f3);
      chk("rsp_rdata", rsp_rdata, m_rsp_data);
    end
    chk("fault", fault, m_fault);
    if (m_fault) chk("fault_addr", fault_addr, m_fault_addr);
  end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic set_req(bit w, logic [2:0] f, logic [31:0] a, logic [31:0] d);
    req_valid = 1; req_we = w; req_f3 = f; req_addr = a; req_wdata = d;
  endtask
  task automatic issue(bit w, logic [2:0] f, logic [31:0] a, logic [31:0] d);
    bit acc = 0;
    set_req(w, f, a, d);
    for (int n = 0; n < 50 && !acc; n++) begin
      #1;
      acc = ready;
      @(posedge clk);
      #2;
    end
    if (!acc) begin
      errors++;
      $display("FAIL issue_timeout addr %h never accepted", a);
    end
  endtask
  task automatic idle();
    req_valid = 0;
  endtask
  initial begin
    rvalid = 1;
    repeat (3) cyc();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_ready", ready, 0);
    rst = 0; rvalid = 0;
    #1 chk("ready_after_rst", ready, 1);
    gnt = 1;
    issue(1, 3'd0, 32'h103, 32'h000000A5);
    chk("sb_be", mem_be, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("sb_addr", mem_addr, 30'h40);
    issue(1, 3'd1, 32'h102, 32'h00001234);
    chk("sh_be", mem_be, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    issue(1, 3'd2, 32'h100, 32'hDEADBEEF);
    chk("sw_be", mem_be, 4'b1111);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    idle();
    cyc();
    issue(0, 3'd4, 32'h201, 0);
    idle();
    chk("lbu_req", mem_req, 1);
    chk("lbu_be", mem_be, 4'b0000);
    cyc();
    chk("lbu_no_rsp_yet", rsp_valid, 0);
    rvalid = 1; rdata = 32'h11223344;
    cyc();
    rvalid = 0;
    chk("lbu_rsp_valid", rsp_valid, 1);
    chk("lbu_rsp_addr", rsp_addr, 2'b01);
    chk("lbu_rsp_f3", rsp_f3, 3'b100);
    chk("lbu_rsp_data", rsp_rdata, 32'h11223344);
    cyc();
    issue(0, 3'd2, 32'h400, 0);
    issue(0, 3'd1, 32'h406, 0);
    set_req(0, 3'd0, 32'h409, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready_low", ready, 0);
      if (i < 2) cyc();
    end
    rvalid = 1; rdata = 32'hAAAA0001;
    #1 chk("bp_ready_pop_ignored", ready, 0);
    cyc();
    rvalid = 0;
    chk("bp_rsp1_valid", rsp_valid, 1);
    chk("bp_rsp1_addr", rsp_addr, 2'b00);
    chk("bp_rsp1_f3", rsp_f3, 3'b010);
    #1 chk("bp_ready_freed", ready, 1);
    gnt = 0;
    cyc();
    idle();
    for (int i = 0; i < 4; i++) begin
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, 30'h102);
      cyc();
    end
    gnt = 1;
    cyc();
    rvalid = 1; rdata = 32'hBBBB0002;
    cyc();
    chk("bp_rsp2_addr", rsp_addr, 2'b10);
    chk("bp_rsp2_f3", rsp_f3, 3'b001);
    rdata = 32'hCCCC0003;
    cyc();
    rvalid = 0;
    chk("bp_rsp3_addr", rsp_addr, 2'b01);
    chk("bp_rsp3_data", rsp_rdata, 32'hCCCC0003);
    cyc();
    issue(0, 3'd2, 32'h302, 0);
    idle();
    chk("lw_fault", fault, 1);
    chk("lw_fault_addr", fault_addr, 32'h302);
    chk("lw_fault_noreq", mem_req, 0);
    cyc();
    chk("fault_pulse", fault, 0);
    issue(1, 3'd1, 32'h001, 32'h5555);
    idle();
    chk("sh_fault", fault, 1);
    chk("sh_fault_addr", fault_addr, 32'h001);
    chk("sh_fault_noreq", mem_req, 0);
    issue(0, 3'd3, 32'h500, 0);
    chk("ld011_fault", fault, 1);
    issue(1, 3'd4, 32'h504, 0);
    idle();
    chk("st100_fault", fault, 1);
    cyc();
    issue(0, 3'd2, 32'h600, 0);
    issue(0, 3'd2, 32'h604, 0);
    idle();
    rvalid = 1; rdata = 32'h60000000;
    cyc();
    rvalid = 0;
    chk("sim_rsp_valid", rsp_valid, 1);
    #1 chk("sim_count_one", ready, 1);
    rvalid = 1; rdata = 32'h60400000;
    cyc();
    rvalid = 0;
    chk("sim_rsp2", rsp_rdata, 32'h60400000);
    cyc();
    issue(0, 3'd1, 32'h700, 0);
    issue(0, 3'd4, 32'h703, 0);
    idle();
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_pend_noreq", mem_req, 0);
    rvalid = 1;
    cyc();
    chk("late_rvalid1", rsp_valid, 0);
    cyc();
    chk("late_rvalid2", rsp_valid, 0);
    rvalid = 0;
    gnt = 0;
    issue(1, 3'd2, 32'h800, 32'h1);
    idle();
    cyc();
    chk("held_req", mem_req, 1);
    rst = 1;
    cyc();
    rst = 0;
    chk("held_dropped", mem_req, 0);
    gnt = 1;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
